// File: rtl/data_mem_pkg.sv
// Shared defaults and FSM state encoding for the data memory responder.
// No ports; imported by data_mem_array and data_mem_responder.
package data_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : data_mem_pkg

// File: rtl/data_mem_array.sv
// Word-addressed storage: synchronous write, asynchronous read, no reset.
// Ports:
//   clk     - write clock
//   we      - write enable, commits wdata to addr on the rising edge
//   addr    - word address for both the write and the combinational read
//   wdata   - write data
//   rdata_c - combinational read of mem[addr]
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule : data_mem_array

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder: accepts one access while idle, then acks it
// exactly LATENCY cycles later with a one-cycle pulse.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   req        - access request, held by the requester until accepted
//   we         - 1 = write, 0 = read (sampled on acceptance)
//   addr       - word address (sampled on acceptance)
//   wdata      - write data (sampled on acceptance)
//   ready      - responder idle, a request this cycle is accepted
//   ack        - one-cycle completion pulse
//   rdata      - read result, updated only by read responses
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);

  // Counter load; LATENCY=1 bypasses WAIT so the load value is unused there.
  localparam int unsigned CNT_LOAD_I = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_LOAD_I);
  localparam bit DIRECT_RESP = (LATENCY == 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_d;
  logic              ready_d, ack_d;

  logic              enter_resp_c;
  logic              commit_we_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata_c;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we_c),
    .addr    (mem_addr_c),
    .wdata   (mem_wdata_c),
    .rdata_c (mem_rdata_c)
  );

  // State, counter, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ready   <= 1'b1;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      ack     <= ack_d;
    end
  end

  // Next state; the memory is written or read on the edge entering RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata;
    enter_resp_c = 1'b0;
    commit_we_c  = 1'b0;
    mem_addr_c   = addr_q;
    mem_wdata_c  = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (DIRECT_RESP) begin
            // Latches are not loaded yet, so the access uses the live inputs.
            state_d      = RESP;
            enter_resp_c = 1'b1;
            commit_we_c  = we;
            mem_addr_c   = addr;
            mem_wdata_c  = wdata;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
          commit_we_c  = we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_we_c = enter_resp_c & commit_we_c;
    if (enter_resp_c && !commit_we_c) begin
      rdata_d = mem_rdata_c;
    end

    ready_d = (state_d == IDLE);
    ack_d   = (state_d == RESP);
  end

endmodule : data_mem_responder

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Param LATENCY, default 4, cycles from request acceptance to ack; legal range 1..15.
REQ-002 Param ADDR_W, default 8, word-address width.
REQ-003 Param DATA_W, default 32, data word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  1  requester asserts to issue an access; holds until accepted.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  ADDR_W  word address; sampled with req.
REQ-009 wdata  input  DATA_W  write data; sampled with req.
REQ-010 ready  output  1  1 = responder idle, can accept a request this cycle.
REQ-011 ack  output  1  one-cycle pulse marking completion of the accepted access.
REQ-012 rdata  output  DATA_W  read result; valid while ack=1 for reads.

Function
REQ-013 Acceptance occurs on a rising edge where ready=1 and req=1; addr, we and wdata are latched at that edge.
REQ-014 FSM has three states: IDLE (ready=1, ack=0), WAIT (ready=0, ack=0), RESP (ready=0, ack=1).
REQ-015 IDLE moves to WAIT on acceptance when LATENCY>1, or directly to RESP when LATENCY=1.
REQ-016 WAIT uses a 4-bit down-counter loaded with LATENCY-2 on acceptance; the FSM enters RESP on the edge where the counter equals 0.
REQ-017 ack is high exactly LATENCY cycles after the accepting edge and lasts exactly one cycle.
REQ-018 RESP always returns to IDLE on the next edge; ready is high again in the cycle after ack.
REQ-019 A req arriving while ready=0 is ignored and no state is latched; with req held continuously, the next acceptance occurs in the first cycle after ack.
REQ-020 A write updates the storage array at the edge entering RESP; rdata holds its prior value.
REQ-021 A read loads rdata from the array at the edge entering RESP; rdata holds that value until the next read response.
REQ-022 A read following a write to the same address returns the newly written data.
REQ-023 Storage is 2**ADDR_W words; all addresses are valid; there is no wrap or error condition.
REQ-024 we and wdata are ignored for reads; wdata is ignored whenever no acceptance occurs.

Reset
REQ-025 While rst_n=0: state=IDLE, ready=1, ack=0, rdata=0, counter=0, latched request registers=0.
REQ-026 Storage array contents are not reset; their value after reset is undefined.
REQ-027 Reset asserted mid-access aborts the access: no ack is issued, and a write not yet committed is not committed.
REQ-028 The first acceptance can occur on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package data_mem_pkg holds the ADDR_W and DATA_W defaults, the LATENCY default, and the FSM state enumeration (IDLE, WAIT, RESP).
REQ-030 Storage is one sub-module, data_mem_array: synchronous write (clk, we, addr, wdata) and asynchronous read; it has no reset.
REQ-031 The top level contains only the FSM, the counter, the request latches and the rdata register.

Verification
REQ-032 LATENCY=4: write addr 0x10 data 0xDEADBEEF accepted at edge E -> ack high only in cycle E+4; ready low from E+1 through E+4 and high at E+5.
REQ-033 Read addr 0x10 after REQ-032 -> ack after 4 cycles with rdata=0xDEADBEEF; rdata holds 0xDEADBEEF after ack falls.
REQ-034 Back-to-back: req held high with reads of 0x00 then 0xFF -> two acks exactly 5 cycles apart; the second read is not accepted while ready=0.
REQ-035 LATENCY=1: write 0x01 then read 0x01 -> each ack arrives 1 cycle after acceptance; read returns the written value.
REQ-036 rst_n pulsed low 2 cycles after accepting a write of 0x12345678 to 0x20 -> no ack; ready=1, rdata=0; a later read of 0x20 does not return 0x12345678 (preloaded 0 via a completed write first).
REQ-037 Sweep all 256 addresses, writing data=addr*0x01010101, then read back -> every rdata matches and 512 acks are observed.
